// File: rtl/stream_trans_sched.sv
// Multi-channel stream transfer scheduler: per-channel descriptor FIFOs, in-order command issue
// by global sequence index, and routing of the selected channel onto one AXI-Stream master.
// Optional feature macro: STREAM_TRANS_SCHED_TKEEP_EN (byte lengths plus m_axis_tkeep).
module stream_trans_sched #(
   parameter  int N_CH       = 4,
   parameter  int DESC_DEPTH = 8,
   parameter  int OFFSET_WDT = 32,
   parameter  int LEN_WDT    = 16,
   parameter  int SEQ_WDT    = 16,
   parameter  int TDATA_WDT  = 64,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      desc_valid,
   output logic                      desc_ready,
   input  logic [CH_W-1:0]           desc_ch,
   input  logic [OFFSET_WDT-1:0]     desc_offset,
   input  logic [LEN_WDT-1:0]        desc_len,
   input  logic [SEQ_WDT-1:0]        desc_seq,
   output logic                      cmd_valid,
   input  logic                      cmd_ready,
   output logic [CH_W-1:0]           cmd_ch,
   output logic [OFFSET_WDT-1:0]     cmd_offset,
   output logic [LEN_WDT-1:0]        cmd_len,
   input  logic [N_CH-1:0]           s_axis_tvalid,
   output logic [N_CH-1:0]           s_axis_tready,
   input  logic [N_CH*TDATA_WDT-1:0] s_axis_tdata,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [TDATA_WDT-1:0]      m_axis_tdata,
   output logic                      m_axis_tlast,
`ifdef STREAM_TRANS_SCHED_TKEEP_EN
   output logic [TDATA_WDT/8-1:0]    m_axis_tkeep,
`endif
   output logic [SEQ_WDT-1:0]        seq_exp,
   output logic                      seq_err,
   output logic                      busy
);

   localparam int PTR_W = $clog2(DESC_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

   typedef struct packed {
      logic [SEQ_WDT-1:0]    seq;
      logic [LEN_WDT-1:0]    len;
      logic [OFFSET_WDT-1:0] off;
   } desc_t;

   desc_t               r_mem [N_CH][DESC_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr [N_CH];
   logic [PTR_W-1:0]    r_rd_ptr [N_CH];
   logic [CNT_W-1:0]    r_cnt [N_CH];
   state_t              r_state, w_state_nxt;
   logic [CH_W-1:0]     r_ch;
   logic [OFFSET_WDT-1:0] r_off;
   logic [LEN_WDT-1:0]  r_len, r_beats, w_beat_cnt;
   logic [SEQ_WDT-1:0]  r_seq_exp;
   logic                r_seq_err;

   logic [N_CH-1:0]     w_push, w_pop;
   logic                w_desc_ready;
   desc_t               w_head [N_CH];
   desc_t               w_match;
   logic                w_stale_hit, w_match_hit;
   logic [CH_W-1:0]     w_stale_ch, w_match_ch;
   logic                w_drop, w_take, w_skip, w_beat, w_load;

   // Readiness comes from the registered occupancy only, so a full FIFO stays
   // not-ready even in a cycle where it is also being popped.
   always_comb begin
      w_desc_ready = 1'b0;
      w_push       = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (desc_ch == CH_W'(i)) w_desc_ready = (r_cnt[i] != CNT_W'(DESC_DEPTH));
      end
      for (int i = 0; i < N_CH; i++) begin
         w_push[i] = desc_valid && w_desc_ready && (desc_ch == CH_W'(i));
      end
   end

   assign desc_ready = w_desc_ready;

   // Head scan runs from the top channel down so the lowest channel overwrites last and wins.
   always_comb begin
      w_stale_hit = 1'b0;
      w_stale_ch  = '0;
      w_match_hit = 1'b0;
      w_match_ch  = '0;
      w_match     = '0;
      for (int i = 0; i < N_CH; i++) w_head[i] = r_mem[i][r_rd_ptr[i]];
      for (int i = N_CH - 1; i >= 0; i--) begin
         if ((r_cnt[i] != '0) && (w_head[i].seq < r_seq_exp)) begin
            w_stale_hit = 1'b1;
            w_stale_ch  = CH_W'(i);
         end
         if ((r_cnt[i] != '0) && (w_head[i].seq == r_seq_exp)) begin
            w_match_hit = 1'b1;
            w_match_ch  = CH_W'(i);
            w_match     = w_head[i];
         end
      end
   end

   assign w_beat = (r_state == STREAM) && m_axis_tvalid && m_axis_tready;
   assign w_load = (r_state == ISSUE) && cmd_ready;

   // NOTE: every signal driven here gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = '0;
      w_drop      = 1'b0;
      w_take      = 1'b0;
      w_skip      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_stale_hit) begin
               w_pop[w_stale_ch] = 1'b1;
               w_drop            = 1'b1;
            end else if (w_match_hit) begin
               w_pop[w_match_ch] = 1'b1;
               if (w_match.len == '0) begin
                  w_skip = 1'b1;
               end else begin
                  w_take      = 1'b1;
                  w_state_nxt = ISSUE;
               end
            end
         end
         ISSUE:   if (cmd_ready) w_state_nxt = STREAM;
         STREAM:  if (w_beat && (r_beats == LEN_WDT'(1))) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            r_wr_ptr[i] <= '0;
            r_rd_ptr[i] <= '0;
            r_cnt[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
            if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
            r_cnt[i] <= r_cnt[i] + CNT_W'(w_push[i]) - CNT_W'(w_pop[i]);
         end
      end
   end

   // NOTE: descriptor storage has no reset; the occupancy counters alone decide what is valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++) begin
         if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= '{seq: desc_seq, len: desc_len, off: desc_offset};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch      <= '0;
         r_off     <= '0;
         r_len     <= '0;
         r_beats   <= '0;
         r_seq_exp <= '0;
         r_seq_err <= 1'b0;
      end else begin
         if (w_drop) r_seq_err <= 1'b1;
         if (w_take) begin
            r_ch  <= w_match_ch;
            r_off <= w_match.off;
            r_len <= w_match.len;
         end
         if (w_load)      r_beats <= w_beat_cnt;
         else if (w_beat) r_beats <= r_beats - LEN_WDT'(1);
         if (w_skip || (w_beat && (r_beats == LEN_WDT'(1)))) r_seq_exp <= r_seq_exp + SEQ_WDT'(1);
      end
   end

`ifdef STREAM_TRANS_SCHED_TKEEP_EN
   localparam int                 KEEP_W = TDATA_WDT / 8;
   localparam logic [LEN_WDT-1:0] BYTES  = LEN_WDT'(KEEP_W);

   logic [LEN_WDT-1:0] w_rem;
   logic [KEEP_W-1:0]  w_last_keep, r_last_keep;

   // A byte remainder of zero means the final beat is full.
   always_comb begin
      w_rem       = r_len % BYTES;
      w_beat_cnt  = (r_len / BYTES) + ((w_rem != '0) ? LEN_WDT'(1) : LEN_WDT'(0));
      w_last_keep = '1;
      if (w_rem != '0) begin
         for (int k = 0; k < KEEP_W; k++) w_last_keep[k] = (LEN_WDT'(k) < w_rem);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)         r_last_keep <= '0;
      else if (w_load) r_last_keep <= w_last_keep;
   end

   assign m_axis_tkeep = (r_state != STREAM) ? '0 : (m_axis_tlast ? r_last_keep : '1);
`else
   assign w_beat_cnt = r_len;
`endif

   always_comb begin
      s_axis_tready = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      if (r_state == STREAM) begin
         for (int i = 0; i < N_CH; i++) begin
            if (r_ch == CH_W'(i)) begin
               s_axis_tready[i] = m_axis_tready;
               m_axis_tvalid    = s_axis_tvalid[i];
               m_axis_tdata     = s_axis_tdata[i*TDATA_WDT +: TDATA_WDT];
            end
         end
      end
   end

   assign m_axis_tlast = (r_state == STREAM) && (r_beats == LEN_WDT'(1));
   assign cmd_valid    = (r_state == ISSUE);
   assign cmd_ch       = r_ch;
   assign cmd_offset   = r_off;
   assign cmd_len      = r_len;
   assign seq_exp      = r_seq_exp;
   assign seq_err      = r_seq_err;
   assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_stream_trans_sched.sv
// Bench for stream_trans_sched: directed scenarios plus randomized batches checked every cycle
// against an in-order command list and per-channel routing expectations.
module tb_stream_trans_sched;

   localparam int N_CH = 4;
   localparam int TDW  = 64;
`ifdef STREAM_TRANS_SCHED_TKEEP_EN
   localparam int UNIT = 8;
`else
   localparam int UNIT = 1;
`endif

   typedef struct {
      int          ch;
      logic [31:0] off;
      logic [15:0] len;
      logic [15:0] seq;
   } cmd_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              desc_valid = 1'b0;
   logic              desc_ready;
   logic [1:0]        desc_ch = '0;
   logic [31:0]       desc_offset = '0;
   logic [15:0]       desc_len = '0;
   logic [15:0]       desc_seq = '0;
   logic              cmd_valid;
   logic              cmd_ready = 1'b0;
   logic [1:0]        cmd_ch;
   logic [31:0]       cmd_offset;
   logic [15:0]       cmd_len;
   logic [N_CH-1:0]   s_axis_tvalid = '0;
   logic [N_CH-1:0]   s_axis_tready;
   logic [N_CH*TDW-1:0] s_axis_tdata = '0;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b0;
   logic [TDW-1:0]    m_axis_tdata;
   logic              m_axis_tlast;
   logic [7:0]        m_axis_tkeep;
   logic [15:0]       seq_exp;
   logic              seq_err;
   logic              busy;

   stream_trans_sched dut (
      .clk(clk), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_ch(desc_ch),
      .desc_offset(desc_offset), .desc_len(desc_len), .desc_seq(desc_seq),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch),
      .cmd_offset(cmd_offset), .cmd_len(cmd_len),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tlast(m_axis_tlast),
`ifdef STREAM_TRANS_SCHED_TKEEP_EN
      .m_axis_tkeep(m_axis_tkeep),
`endif
      .seq_exp(seq_exp), .seq_err(seq_err), .busy(busy)
   );

`ifndef STREAM_TRANS_SCHED_TKEEP_EN
   assign m_axis_tkeep = 8'h00;
`endif

   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: the commands still owed in sequence order, and the transfer in flight.
   cmd_t        exp_cmds[$];
   int          issued_ch[$];
   bit          act_valid = 1'b0;
   int          act_ch = 0;
   int          act_rem = 0;
   logic [15:0] act_len = '0;
   bit          stale_pushed = 1'b0;
   bit          mon_en = 1'b0;
   int          n_cmd = 0;
   int          n_beats = 0;
   int          n_tlast = 0;
   logic [7:0]  last_keep = '0;
   logic [15:0] model_seq = '0;

   function automatic int beats_of(input logic [15:0] len);
      return (int'(len) + UNIT - 1) / UNIT;
   endfunction

   function automatic logic [7:0] keep_of(input logic [15:0] len);
      int rem;
      rem = int'(len) % 8;
      return (rem == 0) ? 8'hFF : 8'((1 << rem) - 1);
   endfunction

   // Random sink/source behaviour, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      cmd_ready     = ($urandom_range(0, 99) < 70);
      m_axis_tready = ($urandom_range(0, 99) < 75);
      for (int i = 0; i < N_CH; i++) s_axis_tvalid[i] = ($urandom_range(0, 99) < 75);
      for (int i = 0; i < N_CH * TDW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
   end

   logic [N_CH-1:0] tr_exp;
   logic            tv_exp;
   logic [7:0]      keep_exp;
   cmd_t            head;

   always @(negedge clk) begin
      if (mon_en) begin
         tr_exp = '0;
         tv_exp = 1'b0;
         if (act_valid) begin
            tr_exp[act_ch] = m_axis_tready;
            tv_exp         = s_axis_tvalid[act_ch];
         end
         check("s_axis_tready", 64'(s_axis_tready), 64'(tr_exp));
         check("m_axis_tvalid", 64'(m_axis_tvalid), 64'(tv_exp));
         if (tv_exp) check("m_axis_tdata", m_axis_tdata, s_axis_tdata[act_ch*TDW +: TDW]);
         check("m_axis_tlast", 64'(m_axis_tlast), 64'(act_valid && (act_rem == 1)));
`ifdef STREAM_TRANS_SCHED_TKEEP_EN
         keep_exp = act_valid ? ((act_rem == 1) ? keep_of(act_len) : 8'hFF) : 8'h00;
         check("m_axis_tkeep", 64'(m_axis_tkeep), 64'(keep_exp));
`endif
         if (!stale_pushed) check("seq_err_early", 64'(seq_err), 64'(0));
         if (act_valid) check("busy_stream", 64'(busy), 64'(1));
         if (cmd_valid) begin
            if (act_valid || (exp_cmds.size() == 0)) begin
               check("cmd_unexpected", 64'(cmd_valid), 64'(0));
            end else begin
               head = exp_cmds[0];
               check("cmd_ch", 64'(cmd_ch), 64'(head.ch));
               check("cmd_offset", 64'(cmd_offset), 64'(head.off));
               check("cmd_len", 64'(cmd_len), 64'(head.len));
               check("seq_exp_at_cmd", 64'(seq_exp), 64'(head.seq));
               check("busy_issue", 64'(busy), 64'(1));
               if (cmd_ready) begin
                  void'(exp_cmds.pop_front());
                  act_valid = 1'b1;
                  act_ch    = head.ch;
                  act_len   = head.len;
                  act_rem   = beats_of(head.len);
                  n_cmd++;
                  issued_ch.push_back(head.ch);
               end
            end
         end else if (tv_exp && m_axis_tready) begin
            n_beats++;
            if (m_axis_tlast) begin
               n_tlast++;
               last_keep = m_axis_tkeep;
            end
            act_rem--;
            if (act_rem == 0) act_valid = 1'b0;
         end
      end
   end

   // Called just after a rising edge; the push lands on the first edge that sees desc_ready.
   task automatic push(input cmd_t d);
      int n;
      n           = 0;
      desc_ch     = 2'(d.ch);
      desc_offset = d.off;
      desc_len    = d.len;
      desc_seq    = d.seq;
      desc_valid  = 1'b1;
      @(negedge clk);
      while (!desc_ready && (n < 300)) begin
         n++;
         @(negedge clk);
      end
      if (n >= 300) check("push_ready_timeout", 64'(desc_ready), 64'(1));
      @(posedge clk);
      #2;
      desc_valid = 1'b0;
   endtask

   task automatic wait_drain(input logic [15:0] target);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!((exp_cmds.size() == 0) && !act_valid && !busy && (seq_exp == target)) && (n < 3000));
      check("drain_seq_exp", 64'(seq_exp), 64'(target));
      check("drain_cmds_left", 64'(exp_cmds.size()), 64'(0));
   endtask

   task automatic check_reset_values();
      check("rst_desc_ready", 64'(desc_ready), 64'(1));
      check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("rst_cmd_ch", 64'(cmd_ch), 64'(0));
      check("rst_cmd_offset", 64'(cmd_offset), 64'(0));
      check("rst_cmd_len", 64'(cmd_len), 64'(0));
      check("rst_s_tready", 64'(s_axis_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'(0));
      check("rst_m_tdata", m_axis_tdata, 64'(0));
      check("rst_m_tlast", 64'(m_axis_tlast), 64'(0));
      check("rst_m_tkeep", 64'(m_axis_tkeep), 64'(0));
      check("rst_seq_exp", 64'(seq_exp), 64'(0));
      check("rst_seq_err", 64'(seq_err), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
   endtask

   cmd_t        chq[N_CH][$];
   cmd_t        d;
   int          cnt[N_CH];
   int          b0, t0, c0, i0, k, ch, n;
   bit          stale_batch;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      check_reset_values();
      rst    = 1'b0;
      mon_en = 1'b1;

      // One 4-beat transfer on ch1.
      b0 = n_beats; t0 = n_tlast;
      d = '{1, 32'h100, 16'(4 * UNIT), 16'd0};
      exp_cmds.push_back(d);
      push(d);
      wait_drain(16'd1);
      check("t1_beats", 64'(n_beats - b0), 64'(4));
      check("t1_tlast_count", 64'(n_tlast - t0), 64'(1));
      check("t1_seq_exp", 64'(seq_exp), 64'(1));

      // Later sequence pushed first on ch0; ch2 must still be issued first.
      i0 = issued_ch.size();
      exp_cmds.push_back('{2, 32'h220, 16'(3 * UNIT), 16'd1});
      exp_cmds.push_back('{0, 32'h200, 16'(3 * UNIT), 16'd2});
      push('{0, 32'h200, 16'(3 * UNIT), 16'd2});
      push('{2, 32'h220, 16'(3 * UNIT), 16'd1});
      wait_drain(16'd3);
      check("t2_first_ch", 64'(issued_ch[i0]), 64'(2));
      check("t2_second_ch", 64'(issued_ch[i0 + 1]), 64'(0));

      // Zero-length descriptor consumes its sequence index without a command.
      c0 = n_cmd;
      exp_cmds.push_back('{0, 32'h400, 16'(2 * UNIT), 16'd4});
      push('{3, 32'h300, 16'd0, 16'd3});
      push('{0, 32'h400, 16'(2 * UNIT), 16'd4});
      wait_drain(16'd5);
      check("t3_cmd_count", 64'(n_cmd - c0), 64'(1));
      check("t3_seq_exp", 64'(seq_exp), 64'(5));

      // Stale descriptor is dropped and flags the sticky error.
      c0 = n_cmd;
      stale_pushed = 1'b1;
      push('{3, 32'h500, 16'(3 * UNIT), 16'd1});
      repeat (10) @(posedge clk);
      #2;
      check("t4_seq_err", 64'(seq_err), 64'(1));
      check("t4_seq_exp", 64'(seq_exp), 64'(5));
      check("t4_no_cmd", 64'(n_cmd - c0), 64'(0));
      model_seq = 16'd5;

      // Randomized batches: per-channel increasing sequences, interleaved pushes, some stale.
      for (int b = 0; b < 8; b++) begin
         k           = $urandom_range(4, 12);
         stale_batch = 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            chq[i].delete();
            cnt[i] = 0;
         end
         for (int s = 0; s < k; s++) begin
            do ch = $urandom_range(0, N_CH - 1); while (cnt[ch] >= 7);
            if (($urandom_range(0, 9) == 0) && (cnt[ch] < 6)) begin
               chq[ch].push_back('{ch, $urandom, 16'(UNIT), model_seq - 16'($urandom_range(1, 3))});
               cnt[ch]++;
               stale_batch = 1'b1;
            end
            d.ch  = ch;
            d.off = $urandom;
            d.len = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 5 * UNIT));
            d.seq = model_seq + 16'(s);
            chq[ch].push_back(d);
            cnt[ch]++;
            if (d.len != 16'd0) exp_cmds.push_back(d);
         end
         if (stale_batch) stale_pushed = 1'b1;
         n = k;
         for (int i = 0; i < N_CH; i++) n = (i == 0) ? chq[0].size() : n + chq[i].size();
         while (n > 0) begin
            do ch = $urandom_range(0, N_CH - 1); while (chq[ch].size() == 0);
            push(chq[ch].pop_front());
            n--;
         end
         model_seq = model_seq + 16'(k);
         wait_drain(model_seq);
         check("batch_seq_err", 64'(seq_err), 64'(1));
      end

      // Fill ch0 with descriptors that cannot match yet; ch0 becomes full, ch1 stays open.
      for (int i = 0; i < 8; i++) push('{0, 32'h1000 + 32'(i), 16'(UNIT), model_seq + 16'(100 + i)});
      repeat (3) @(posedge clk);
      #2;
      desc_ch = 2'd0;
      #1;
      check("full_ch0_ready", 64'(desc_ready), 64'(0));
      desc_ch = 2'd1;
      #1;
      check("open_ch1_ready", 64'(desc_ready), 64'(1));

      // Reset lands during the second beat of a 6-beat transfer.
      d = '{1, 32'hABC0, 16'(6 * UNIT), model_seq};
      exp_cmds.push_back(d);
      push(d);
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (!(act_valid && (act_rem == 5)) && (n < 500));
      check("second_beat_reached", 64'(act_rem), 64'(5));
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #2;
      check_reset_values();
      rst = 1'b0;
      exp_cmds.delete();
      act_valid    = 1'b0;
      stale_pushed = 1'b0;
      model_seq    = 16'd0;
      mon_en       = 1'b1;

      // The FIFOs were emptied and the aborted transfer is not resumed.
      c0 = n_cmd;
      exp_cmds.push_back('{0, 32'h40, 16'(2 * UNIT), 16'd0});
      push('{0, 32'h40, 16'(2 * UNIT), 16'd0});
      wait_drain(16'd1);
      check("post_rst_cmd_count", 64'(n_cmd - c0), 64'(1));
      model_seq = 16'd1;

`ifdef STREAM_TRANS_SCHED_TKEEP_EN
      b0 = n_beats;
      exp_cmds.push_back('{2, 32'h300, 16'd20, model_seq});
      push('{2, 32'h300, 16'd20, model_seq});
      wait_drain(model_seq + 16'd1);
      check("keep_beats", 64'(n_beats - b0), 64'(3));
      check("keep_last", 64'(last_keep), 64'(8'h0F));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
